// File: rtl/bootstrap_loader.sv
// Bootstrap loader: copies a byte stream from a valid/ready source into the
// microcode store, one byte per setup/strobe/hold write cycle, then flags boot done.
module bootstrap_loader #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned LAST_ADDR  = 2**ADDR_WIDTH-1
) (
   input  logic                  N_CLK,
   input  logic                  N_RST,
   input  logic [7:0]            IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
   output logic [7:0]            BOOTSTRAP_DATA,
   output logic                  BOOTSTRAP_N_WE,
   output logic                  N_BOOTED
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(LAST_ADDR);

   state_t                r_state;
   state_t                w_next;
   logic                  r_ready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_data;
   logic                  w_accept;
   logic                  w_last;

   assign w_accept = (r_state == S_WAIT) && r_ready && IN_VALID;
   assign w_last   = (r_addr == LP_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT:   if (w_accept) w_next = S_SETUP;
         S_SETUP:  w_next = S_STROBE;
         S_STROBE: w_next = S_HOLD;
         S_HOLD:   w_next = w_last ? S_DONE : S_WAIT;
         S_DONE:   w_next = S_DONE;
         default:  w_next = S_WAIT;
      endcase
   end

   // Ready is registered from the next state so it stays low throughout reset
   // and rises on the first clock edge after release.
   always_ff @(posedge N_CLK or negedge N_RST) begin
      if (!N_RST) begin
         r_state <= S_WAIT;
         r_ready <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == S_WAIT);
         if (w_accept) begin
            r_data <= IN_DATA;
         end else if ((r_state == S_HOLD) && w_last) begin
            r_data <= '0;
         end
         if (r_state == S_HOLD) begin
            r_addr <= w_last ? '0 : r_addr + 1'b1;
         end
      end
   end

   assign IN_READY       = r_ready;
   assign BOOTSTRAP_ADDR = r_addr;
   assign BOOTSTRAP_DATA = r_data;
   assign BOOTSTRAP_N_WE = (r_state != S_STROBE);
   assign N_BOOTED       = (r_state != S_DONE);

endmodule

// File: tb/tb_bootstrap_loader.sv
// Directed bench: a 4-byte loader instance for protocol/timing scenarios and a
// default-size instance for a full-store random load.
module tb_bootstrap_loader;

   logic        N_CLK;
   logic        N_RST;
   int          checks;
   int          errors;
   int          cyc;

   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] s_addr;
   logic [7:0]  s_bdata;
   logic        s_nwe;
   logic        s_nboot;

   logic [7:0]  f_data;
   logic        f_valid;
   logic        f_ready;
   logic [11:0] f_addr;
   logic [7:0]  f_bdata;
   logic        f_nwe;
   logic        f_nboot;

   bootstrap_loader #(.ADDR_WIDTH(12), .LAST_ADDR(3)) dut_s (
      .N_CLK(N_CLK), .N_RST(N_RST), .IN_DATA(s_data), .IN_VALID(s_valid),
      .IN_READY(s_ready), .BOOTSTRAP_ADDR(s_addr), .BOOTSTRAP_DATA(s_bdata),
      .BOOTSTRAP_N_WE(s_nwe), .N_BOOTED(s_nboot)
   );

   bootstrap_loader dut_f (
      .N_CLK(N_CLK), .N_RST(N_RST), .IN_DATA(f_data), .IN_VALID(f_valid),
      .IN_READY(f_ready), .BOOTSTRAP_ADDR(f_addr), .BOOTSTRAP_DATA(f_bdata),
      .BOOTSTRAP_N_WE(f_nwe), .N_BOOTED(f_nboot)
   );

   initial N_CLK = 1'b0;
   always #5 N_CLK = ~N_CLK;
   always @(posedge N_CLK) cyc++;

   typedef struct {
      logic [11:0] a;
      logic [7:0]  d;
      int          c;
   } wr_t;
   wr_t         wq[$];
   int          acc_q[$];
   logic [7:0]  fb[4];
   int          fg[4];
   int          gap_n;
   int          gap_bad;
   logic        mon_en;
   logic        p_ok;
   logic        p_nwe;
   logic [11:0] p_addr;
   logic [7:0]  p_data;

   // Write log plus strobe-window stability and strobe sanity on the small instance.
   always @(negedge N_CLK) begin
      if (mon_en) begin
         if (!s_nwe) wq.push_back('{s_addr, s_bdata, cyc});
         if (p_ok) begin
            checks++;
            if ((!s_nwe || !p_nwe) && (s_addr !== p_addr || s_bdata !== p_data)) begin
               errors++;
               $display("FAIL strobe_stable: addr %h data %h, required addr %h data %h", s_addr, s_bdata, p_addr, p_data);
            end
            checks++;
            if (!s_nwe && !p_nwe) begin
               errors++;
               $display("FAIL strobe_width: N_WE low %0d cycles in a row, required 1", 2);
            end
         end
         checks++;
         if (!s_nwe && !s_nboot) begin
            errors++;
            $display("FAIL strobe_booted: N_BOOTED %b during strobe, required 1", s_nboot);
         end
         p_ok = 1'b1;
      end else begin
         p_ok = 1'b0;
      end
      p_nwe  = s_nwe;
      p_addr = s_addr;
      p_data = s_bdata;
   end

   task automatic do_reset();
      @(negedge N_CLK);
      N_RST = 1'b0;
      repeat (2) @(negedge N_CLK);
      N_RST = 1'b1;
      @(negedge N_CLK);
   endtask

   // Offers fb[k] after fg[k] idle cycles spent in WAIT; records accept cycles.
   task automatic feed();
      logic done;
      for (int k = 0; k < 4; k++) begin
         int idle;
         idle = 0;
         done = 1'b0;
         for (int t = 0; t < 40 && !done; t++) begin
            @(negedge N_CLK);
            if (s_ready && idle < fg[k]) begin
               s_valid = 1'b0;
               idle++;
               gap_n++;
               if (s_addr !== 12'(k)) gap_bad++;
            end else begin
               s_valid = 1'b1;
               s_data  = fb[k];
               if (s_ready) begin
                  acc_q.push_back(cyc);
                  done = 1'b1;
               end
            end
         end
         if (!done) begin
            errors++;
            $display("FAIL feed_timeout: byte %0d not accepted, required acceptance", k);
         end
      end
      @(negedge N_CLK);
      s_valid = 1'b0;
   endtask

   task automatic wait_booted(output int dcyc);
      dcyc = -1;
      for (int t = 0; t < 20 && dcyc < 0; t++) begin
         if (!s_nboot) dcyc = cyc;
         else @(negedge N_CLK);
      end
   endtask

   task automatic test_reset();
      N_RST = 1'b0;
      #1;
      checks += 5;
      if (s_nwe !== 1'b1) begin errors++; $display("FAIL rst_nwe: got %b want 1", s_nwe); end
      if (s_nboot !== 1'b1) begin errors++; $display("FAIL rst_nbooted: got %b want 1", s_nboot); end
      if (s_addr !== 12'h000) begin errors++; $display("FAIL rst_addr: got %h want 000", s_addr); end
      if (s_bdata !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", s_bdata); end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", s_ready); end
      repeat (2) @(negedge N_CLK);
      N_RST = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_release: got %b want 0", s_ready); end
      @(negedge N_CLK);
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_first_edge: got %b want 1", s_ready); end
   endtask

   task automatic test_stream();
      logic [7:0] exp_d[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      int dcyc;
      wq.delete();
      acc_q.delete();
      fb = exp_d;
      fg = '{0, 0, 0, 0};
      feed();
      wait_booted(dcyc);
      checks += 2;
      if (wq.size() != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", wq.size()); end
      if (dcyc < 0) begin errors++; $display("FAIL stream_booted: N_BOOTED %b want 0", s_nboot); end
      if (wq.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (wq[k].a !== 12'(k) || wq[k].d !== exp_d[k]) begin
               errors++;
               $display("FAIL stream_write%0d: got %h/%h want %h/%h", k, wq[k].a, wq[k].d, 12'(k), exp_d[k]);
            end
         end
         checks++;
         if (dcyc != wq[3].c + 2) begin errors++; $display("FAIL stream_booted_time: got cycle %0d want %0d", dcyc, wq[3].c + 2); end
      end
      if (acc_q.size() == 4) begin
         for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc_q[k] - acc_q[k-1] != 4) begin
               errors++;
               $display("FAIL stream_accept_gap%0d: got %0d want 4", k, acc_q[k] - acc_q[k-1]);
            end
         end
      end
      checks += 3;
      if (s_addr !== 12'h000) begin errors++; $display("FAIL done_addr: got %h want 000", s_addr); end
      if (s_bdata !== 8'h00) begin errors++; $display("FAIL done_data: got %h want 00", s_bdata); end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b want 0", s_ready); end
   endtask

   task automatic test_gaps();
      logic [7:0] exp_d[4] = '{8'h3C, 8'h00, 8'hFF, 8'h96};
      int dcyc;
      do_reset();
      wq.delete();
      gap_n = 0;
      gap_bad = 0;
      fb = exp_d;
      fg = '{0, 5, 2, 3};
      feed();
      wait_booted(dcyc);
      checks += 4;
      if (wq.size() != 4) begin errors++; $display("FAIL gaps_count: got %0d want 4", wq.size()); end
      if (dcyc < 0) begin errors++; $display("FAIL gaps_booted: N_BOOTED %b want 0", s_nboot); end
      if (gap_n != 10) begin errors++; $display("FAIL gaps_idle: got %0d want 10", gap_n); end
      if (gap_bad != 0) begin errors++; $display("FAIL gaps_addr_held: got %0d moves want 0", gap_bad); end
      if (wq.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (wq[k].a !== 12'(k) || wq[k].d !== exp_d[k]) begin
               errors++;
               $display("FAIL gaps_write%0d: got %h/%h want %h/%h", k, wq[k].a, wq[k].d, 12'(k), exp_d[k]);
            end
         end
      end
   endtask

   task automatic test_reset_strobe();
      logic hit;
      int   dcyc;
      int   n;
      do_reset();
      hit = 1'b0;
      n = 0;
      for (int t = 0; t < 40 && !hit; t++) begin
         @(negedge N_CLK);
         if (!s_nwe && s_addr == 12'h002) begin
            hit = 1'b1;
         end else begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(n);
            if (s_ready) n++;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rs_reach_strobe: strobe at addr 2 not seen, required"); end
      mon_en = 1'b0;
      s_valid = 1'b0;
      #2 N_RST = 1'b0;
      #1;
      checks += 4;
      if (s_nwe !== 1'b1) begin errors++; $display("FAIL rs_nwe: got %b want 1", s_nwe); end
      if (s_addr !== 12'h000) begin errors++; $display("FAIL rs_addr: got %h want 000", s_addr); end
      if (s_bdata !== 8'h00) begin errors++; $display("FAIL rs_data: got %h want 00", s_bdata); end
      if (s_nboot !== 1'b1) begin errors++; $display("FAIL rs_nbooted: got %b want 1", s_nboot); end
      @(negedge N_CLK);
      N_RST = 1'b1;
      wq.delete();
      mon_en = 1'b1;
      fb = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
      fg = '{0, 0, 0, 0};
      feed();
      wait_booted(dcyc);
      checks += 2;
      if (wq.size() != 4) begin errors++; $display("FAIL rs_count: got %0d want 4", wq.size()); end
      if (wq.size() > 0 && (wq[0].a !== 12'h000 || wq[0].d !== 8'h5A)) begin
         errors++;
         $display("FAIL rs_first_write: got %h/%h want 000/5a", wq[0].a, wq[0].d);
      end
   endtask

   task automatic test_done_ignore();
      int n0;
      n0 = wq.size();
      s_valid = 1'b1;
      s_data  = 8'hFF;
      for (int t = 0; t < 10; t++) begin
         @(negedge N_CLK);
         checks += 3;
         if (s_ready !== 1'b0) begin errors++; $display("FAIL di_ready%0d: got %b want 0", t, s_ready); end
         if (s_nwe !== 1'b1) begin errors++; $display("FAIL di_nwe%0d: got %b want 1", t, s_nwe); end
         if (s_nboot !== 1'b0) begin errors++; $display("FAIL di_nbooted%0d: got %b want 0", t, s_nboot); end
      end
      s_valid = 1'b0;
      checks += 2;
      if (wq.size() != n0) begin errors++; $display("FAIL di_strobes: got %0d want %0d", wq.size(), n0); end
      if (s_bdata !== 8'h00) begin errors++; $display("FAIL di_data: got %h want 00", s_bdata); end
   endtask

   task automatic test_full_load();
      logic [7:0]  stream[4096];
      logic [7:0]  mem[4096];
      int          idx, wr_idx, strobes, bad_order, stab_bad, mm;
      logic        fin, q_nwe;
      logic [11:0] q_addr;
      logic [7:0]  q_data;
      for (int k = 0; k < 4096; k++) begin
         stream[k] = 8'($urandom);
         mem[k] = ~stream[k];
      end
      do_reset();
      idx = 0; wr_idx = 0; strobes = 0; bad_order = 0; stab_bad = 0; fin = 1'b0;
      q_nwe = f_nwe; q_addr = f_addr; q_data = f_bdata;
      for (int t = 0; t < 4096 * 4 + 50 && !fin; t++) begin
         @(negedge N_CLK);
         if (!f_nwe) begin
            strobes++;
            if (f_addr !== 12'(wr_idx)) bad_order++;
            mem[f_addr] = f_bdata;
            wr_idx++;
         end
         if ((!f_nwe || !q_nwe) && (f_addr !== q_addr || f_bdata !== q_data)) stab_bad++;
         q_nwe = f_nwe; q_addr = f_addr; q_data = f_bdata;
         if (!f_nboot) fin = 1'b1;
         f_valid = 1'b1;
         f_data  = (idx < 4096) ? stream[idx] : 8'h00;
         if (f_ready) idx++;
      end
      f_valid = 1'b0;
      mm = 0;
      for (int k = 0; k < 4096; k++) if (mem[k] !== stream[k]) mm++;
      checks += 5;
      if (!fin) begin errors++; $display("FAIL full_booted: N_BOOTED %b want 0 within budget", f_nboot); end
      if (strobes != 4096) begin errors++; $display("FAIL full_strobes: got %0d want 4096", strobes); end
      if (bad_order != 0) begin errors++; $display("FAIL full_order: got %0d out-of-order want 0", bad_order); end
      if (stab_bad != 0) begin errors++; $display("FAIL full_stable: got %0d changes want 0", stab_bad); end
      if (mm != 0) begin errors++; $display("FAIL full_contents: got %0d mismatched bytes want 0", mm); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      mon_en = 1'b1;
      p_ok = 1'b0;
      s_valid = 1'b0;
      s_data = 8'h00;
      f_valid = 1'b0;
      f_data = 8'h00;
      gap_n = 0;
      gap_bad = 0;
      test_reset();
      test_stream();
      test_gaps();
      test_reset_strobe();
      test_done_ignore();
      test_full_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bootstrap_loader.md
BOOTSTRAP_LOADER -- requirements
Module: bootstrap_loader

Interface
REQ-001 Parameter: ADDR_WIDTH, 12, width of BOOTSTRAP_ADDR (microcode store address bits).
REQ-002 Parameter: LAST_ADDR, 2**ADDR_WIDTH-1, final address written before boot completes.
REQ-003 Port: reset N_RST, asynchronous, active-low; clock N_CLK.
REQ-004 Port: N_CLK  input  1  clock; all state changes on rising edge of N_CLK.
REQ-005 Port: N_RST  input  1  asynchronous active-low reset.
REQ-006 Port: IN_DATA  input  8  byte from boot source, valid when IN_VALID=1.
REQ-007 Port: IN_VALID  input  1  source offers IN_DATA.
REQ-008 Port: IN_READY  output  1  loader accepts byte this cycle.
REQ-009 Port: BOOTSTRAP_ADDR  output  ADDR_WIDTH  microcode store write address.
REQ-010 Port: BOOTSTRAP_DATA  output  8  microcode store write data.
REQ-011 Port: BOOTSTRAP_N_WE  output  1  active-low write strobe to microcode store.
REQ-012 Port: N_BOOTED  output  1  1 while loading; 0 once store fully written (drives store N_OE).

Function
REQ-013 FSM states SHALL be WAIT, SETUP, STROBE, HOLD, DONE.
REQ-014 All outputs SHALL be driven directly from flops or decoded from state only; no combinational path from inputs to outputs.
REQ-015 WAIT: IN_READY=1, BOOTSTRAP_N_WE=1; on IN_VALID=1 at rising edge, byte is accepted, IN_DATA latched into BOOTSTRAP_DATA, go to SETUP.
REQ-016 WAIT with IN_VALID=0: remain in WAIT, address and data unchanged, no timeout.
REQ-017 SETUP: IN_READY=0, BOOTSTRAP_N_WE=1, address/data held; unconditional go to STROBE (one-cycle setup).
REQ-018 STROBE: BOOTSTRAP_N_WE=0 for exactly one cycle, address/data held; unconditional go to HOLD.
REQ-019 HOLD: BOOTSTRAP_N_WE=1, address/data held (one-cycle hold); if BOOTSTRAP_ADDR==LAST_ADDR go to DONE, else increment BOOTSTRAP_ADDR by 1 and go to WAIT.
REQ-020 Address increment SHALL be ADDR_WIDTH-bit unsigned; wrap-around never occurs because LAST_ADDR terminates loading.
REQ-021 Minimum throughput: one byte per 4 cycles (accept-to-accept with IN_VALID held high).
REQ-022 BOOTSTRAP_ADDR and BOOTSTRAP_DATA SHALL not change in any cycle where BOOTSTRAP_N_WE=0, nor in the cycle immediately before or after it.
REQ-023 DONE: N_BOOTED=0, IN_READY=0, BOOTSTRAP_N_WE=1, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0; terminal until reset; IN_VALID ignored.
REQ-024 N_BOOTED SHALL go 0 on the edge entering DONE, i.e. one cycle after the final strobe deasserts.
REQ-025 Exactly LAST_ADDR+1 write strobes SHALL occur per boot, at addresses 0..LAST_ADDR in ascending order, each exactly once.
REQ-026 Bytes SHALL be written in acceptance order; byte k lands at address k.

Reset
REQ-027 N_RST=0 SHALL immediately (asynchronously) force state WAIT, BOOTSTRAP_N_WE=1, N_BOOTED=1, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0.
REQ-028 IN_READY SHALL be 0 while N_RST=0 and 1 from the first rising edge after N_RST deasserts.
REQ-029 Reset mid-load (any state, including STROBE) SHALL abort the strobe immediately and restart loading from address 0; no partial byte is retained.
REQ-030 Reset in DONE SHALL return N_BOOTED to 1 and restart a full load.

Verification
REQ-031 LAST_ADDR=3, IN_VALID held 1, bytes 0xA1,0xB2,0xC3,0xD4 -> four single-cycle strobes at addr 0..3 with matching data, accepts 4 cycles apart, N_BOOTED=0 one cycle after last strobe.
REQ-032 LAST_ADDR=3, IN_VALID toggled with 0-5 idle cycles between bytes -> same write sequence, no strobe while in WAIT, address held during gaps.
REQ-033 N_RST pulsed low during STROBE at addr 2 -> BOOTSTRAP_N_WE=1 within same cycle, addr=0, next accepted byte written to addr 0.
REQ-034 After DONE, IN_VALID=1 with 0xFF for 10 cycles -> IN_READY=0, no strobes, N_BOOTED stays 0.
REQ-035 Default parameters, 4096 random bytes -> store contents equal byte stream; exactly 4096 strobes; BOOTSTRAP_ADDR/DATA stable around every strobe.
REQ-036 Formal/assertion: BOOTSTRAP_N_WE=0 implies N_BOOTED=1; N_WE low never for 2 consecutive cycles.
